// File: rtl/vend_pkg.sv
// vend_pkg: coin values, FSM state and change-coin enums shared by the vending core
package vend_pkg;
    localparam int Q_VAL = 25;
    localparam int D_VAL = 10;
    localparam int N_VAL = 5;
    typedef enum logic [1:0] {ACCEPT, VEND, PAY_OUT} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_Q, COIN_D, COIN_N} coin_t;
    function automatic int coin_value(input coin_t c);
        return c == COIN_Q ? Q_VAL : c == COIN_D ? D_VAL : c == COIN_N ? N_VAL : 0;
    endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: vending bus; master drives coins/sel/cancel/price/restock, slave returns dispense/change/status
interface vend_if #(
    parameter int NUM_BEV  = 4,
    parameter int CREDIT_W = 10
) ();
    localparam int IDX_W = NUM_BEV > 1 ? $clog2(NUM_BEV) : 1;
    logic                        inQuarter;
    logic                        inDime;
    logic                        inNickel;
    logic [NUM_BEV-1:0]          sel;
    logic                        cancel;
    logic [NUM_BEV*CREDIT_W-1:0] price;
    logic                        restock;
    logic [IDX_W-1:0]            restock_idx;
    logic [NUM_BEV-1:0]          outbev;
    logic                        outquarter;
    logic                        outdime;
    logic                        outnickel;
    logic                        coin_reject;
    logic                        deny;
    logic [CREDIT_W-1:0]         credit;
    logic [NUM_BEV-1:0]          empty;
    logic                        busy;
    modport master (
        output inQuarter, inDime, inNickel, sel, cancel, price, restock, restock_idx,
        input  outbev, outquarter, outdime, outnickel, coin_reject, deny, credit, empty, busy
    );
    modport slave (
        input  inQuarter, inDime, inNickel, sel, cancel, price, restock, restock_idx,
        output outbev, outquarter, outdime, outnickel, coin_reject, deny, credit, empty, busy
    );
endinterface

// File: rtl/vend_change_unit.sv
// vend_change_unit: greedy change pick (credit in -> coin, remainder out), purely combinational
import vend_pkg::*;
module vend_change_unit #(
    parameter int CREDIT_W = 10
) (
    input  logic [CREDIT_W-1:0] credit,
    output coin_t               coin,
    output logic [CREDIT_W-1:0] rem
);
    always_comb begin
        coin = credit >= CREDIT_W'(Q_VAL) ? COIN_Q :
               credit >= CREDIT_W'(D_VAL) ? COIN_D :
               credit >= CREDIT_W'(N_VAL) ? COIN_N : COIN_NONE;
        rem  = credit - CREDIT_W'(coin_value(coin));
    end
endmodule

// File: rtl/vend_core.sv
// vend_core: vending FSM (ACCEPT/VEND/PAY_OUT) with credit, stock and change; ports clk, rst, bus (vend_if.slave)
import vend_pkg::*;
module vend_core #(
    parameter int NUM_BEV    = 4,
    parameter int CREDIT_W   = 10,
    parameter int MAX_CREDIT = 500,
    parameter int STOCK_W    = 4
) (
    input logic   clk,
    input logic   rst,
    vend_if.slave bus
);
    localparam int IDX_W = NUM_BEV > 1 ? $clog2(NUM_BEV) : 1;
    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [NUM_BEV-1:0]  nz;
    logic [NUM_BEV-1:0]  bev_q;
    logic                q_q, d_q, n_q, rej_q, deny_q;
    logic [IDX_W-1:0]    pick;
    logic [CREDIT_W-1:0] pick_price;
    logic                any_sel, any_coin, extra_coin, can_vend, vend_go;
    logic [CREDIT_W:0]   coin_val, coin_sum;
    coin_t               pay_coin;
    logic [CREDIT_W-1:0] pay_rem;
    always_comb begin
        pick = '0;
        for (int i = NUM_BEV - 1; i >= 0; i--)
            if (bus.sel[i]) pick = IDX_W'(i);
        pick_price = bus.price[int'(pick)*CREDIT_W +: CREDIT_W];
        any_sel    = |bus.sel;
        any_coin   = bus.inQuarter | bus.inDime | bus.inNickel;
        extra_coin = (bus.inQuarter & (bus.inDime | bus.inNickel)) | (bus.inDime & bus.inNickel);
        can_vend   = credit >= pick_price && nz[pick];
        vend_go    = state == ACCEPT && !bus.cancel && any_sel && can_vend;
        coin_val   = bus.inQuarter ? (CREDIT_W+1)'(Q_VAL) :
                     bus.inDime    ? (CREDIT_W+1)'(D_VAL) :
                     bus.inNickel  ? (CREDIT_W+1)'(N_VAL) : '0;
        coin_sum   = {1'b0, credit} + coin_val;
    end
    vend_change_unit #(.CREDIT_W(CREDIT_W)) u_change (
        .credit(credit),
        .coin  (pay_coin),
        .rem   (pay_rem)
    );
    // restock overrides a same-cycle decrement of the same channel
    for (genvar i = 0; i < NUM_BEV; i++) begin : g_stock
        logic [STOCK_W-1:0] cnt;
        always_ff @(posedge clk)
            if (rst || (bus.restock && bus.restock_idx == IDX_W'(i))) cnt <= '1;
            else if (vend_go && pick == IDX_W'(i)) cnt <= cnt - 1'b1;
        assign nz[i] = |cnt;
    end
    always_ff @(posedge clk) begin
        bev_q  <= '0;
        q_q    <= 1'b0;
        d_q    <= 1'b0;
        n_q    <= 1'b0;
        rej_q  <= 1'b0;
        deny_q <= 1'b0;
        if (rst) begin
            state  <= ACCEPT;
            credit <= '0;
        end else begin
            case (state)
                ACCEPT:
                    if (bus.cancel) begin
                        rej_q <= any_coin;
                        state <= credit != '0 ? PAY_OUT : ACCEPT;
                    end else if (vend_go) begin
                        rej_q  <= any_coin;
                        state  <= VEND;
                        bev_q  <= NUM_BEV'(1) << pick;
                        credit <= credit - pick_price;
                    end else begin
                        deny_q <= any_sel;
                        if (any_coin && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            rej_q  <= extra_coin;
                        end else rej_q <= any_coin;
                    end
                VEND: begin
                    rej_q <= any_coin;
                    state <= credit != '0 ? PAY_OUT : ACCEPT;
                end
                PAY_OUT: begin
                    rej_q <= any_coin;
                    if (credit == '0) state <= ACCEPT;
                    else if (pay_coin == COIN_NONE) begin
                        credit <= '0;
                        state  <= ACCEPT;
                    end else begin
                        q_q    <= pay_coin == COIN_Q;
                        d_q    <= pay_coin == COIN_D;
                        n_q    <= pay_coin == COIN_N;
                        credit <= pay_rem;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end
    assign bus.outbev      = bev_q;
    assign bus.outquarter  = q_q;
    assign bus.outdime     = d_q;
    assign bus.outnickel   = n_q;
    assign bus.coin_reject = rej_q;
    assign bus.deny        = deny_q;
    assign bus.credit      = credit;
    assign bus.empty       = ~nz;
    assign bus.busy        = state != ACCEPT;
endmodule

// File: tb/tb_vend_core.sv
// tb_vend_core: table-driven per-cycle vectors with a scoreboard queue of expected outputs
module tb_vend_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  vend_if #(.NUM_BEV(4), .CREDIT_W(10)) bus ();
  vend_core #(.NUM_BEV(4), .CREDIT_W(10), .MAX_CREDIT(500), .STOCK_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef logic [23:0] out_t;
  typedef struct {
    logic       r;
    logic [2:0] coins;
    logic [3:0] sel;
    logic       cancel;
    logic       rs;
    logic [1:0] ri;
    out_t       exp;
  } step_t;
  step_t tbl[$];
  out_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  function automatic out_t o(input logic [3:0] bev, input logic [2:0] chg, input logic rej,
                             input logic dny, input int cr, input logic [3:0] emp, input logic bsy);
    return {bev, chg, rej, dny, 10'(cr), emp, bsy};
  endfunction
  task automatic add(input logic r, input logic [2:0] coins, input logic [3:0] sel,
                     input logic cancel, input logic rs, input logic [1:0] ri, input out_t e);
    step_t s;
    s.r = r; s.coins = coins; s.sel = sel; s.cancel = cancel; s.rs = rs; s.ri = ri; s.exp = e;
    tbl.push_back(s);
  endtask
  task automatic idle(input out_t e);
    add(0, 3'b000, 4'b0000, 0, 0, 2'd0, e);
  endtask
  out_t act, want;
  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: vector table did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    rst = 1'b1;
    bus.inQuarter = 0; bus.inDime = 0; bus.inNickel = 0;
    bus.sel = '0; bus.cancel = 0; bus.restock = 0; bus.restock_idx = '0;
    bus.price = {10'd42, 10'd50, 10'd10, 10'd75};
    @(posedge clk);
    #1;
    act = {bus.outbev, bus.outquarter, bus.outdime, bus.outnickel, bus.coin_reject,
           bus.deny, bus.credit, bus.empty, bus.busy};
    checks++;
    if (act !== o(0, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset state: got %b", act);
    end
    add(1, 3'b000, 4'b0000, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) add(0, 3'b100, 0, 0, 0, 0, o(0, 0, 0, 0, 25*k, 0, 0));
    add(0, 3'b000, 4'b0001, 0, 0, 0, o(4'b0001, 0, 0, 0, 25, 0, 1));
    idle(o(0, 0, 0, 0, 25, 0, 1));
    idle(o(0, 3'b100, 0, 0, 0, 0, 1));
    idle(o(0, 0, 0, 0, 0, 0, 0));
    add(0, 3'b010, 0, 0, 0, 0, o(0, 0, 0, 0, 10, 0, 0));
    add(0, 3'b001, 0, 0, 0, 0, o(0, 0, 0, 0, 15, 0, 0));
    add(0, 3'b000, 4'b0100, 0, 0, 0, o(0, 0, 0, 1, 15, 0, 0));
    add(0, 3'b000, 0, 1, 0, 0, o(0, 0, 0, 0, 15, 0, 1));
    idle(o(0, 3'b010, 0, 0, 5, 0, 1));
    idle(o(0, 3'b001, 0, 0, 0, 0, 1));
    idle(o(0, 0, 0, 0, 0, 0, 0));
    add(0, 3'b000, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 19; k++) add(0, 3'b100, 0, 0, 0, 0, o(0, 0, 0, 0, 25*k, 0, 0));
    add(0, 3'b010, 0, 0, 0, 0, o(0, 0, 0, 0, 485, 0, 0));
    add(0, 3'b001, 0, 0, 0, 0, o(0, 0, 0, 0, 490, 0, 0));
    add(0, 3'b100, 0, 0, 0, 0, o(0, 0, 1, 0, 490, 0, 0));
    add(0, 3'b001, 0, 0, 0, 0, o(0, 0, 0, 0, 495, 0, 0));
    add(0, 3'b000, 0, 1, 0, 0, o(0, 0, 0, 0, 495, 0, 1));
    for (int k = 1; k <= 19; k++) idle(o(0, 3'b100, 0, 0, 495 - 25*k, 0, 1));
    idle(o(0, 3'b010, 0, 0, 10, 0, 1));
    idle(o(0, 3'b010, 0, 0, 0, 0, 1));
    idle(o(0, 0, 0, 0, 0, 0, 0));
    add(0, 3'b111, 0, 0, 0, 0, o(0, 0, 1, 0, 25, 0, 0));
    add(0, 3'b010, 4'b0010, 0, 0, 0, o(4'b0010, 0, 1, 0, 15, 0, 1));
    idle(o(0, 0, 0, 0, 15, 0, 1));
    add(0, 3'b100, 0, 0, 0, 0, o(0, 3'b010, 1, 0, 5, 0, 1));
    idle(o(0, 3'b001, 0, 0, 0, 0, 1));
    idle(o(0, 0, 0, 0, 0, 0, 0));
    add(0, 3'b100, 0, 0, 0, 0, o(0, 0, 0, 0, 25, 0, 0));
    add(0, 3'b100, 0, 0, 0, 0, o(0, 0, 0, 0, 50, 0, 0));
    add(0, 3'b000, 4'b1000, 0, 0, 0, o(4'b1000, 0, 0, 0, 8, 0, 1));
    idle(o(0, 0, 0, 0, 8, 0, 1));
    idle(o(0, 3'b001, 0, 0, 3, 0, 1));
    idle(o(0, 0, 0, 0, 0, 0, 0));
    add(0, 3'b100, 0, 0, 0, 0, o(0, 0, 0, 0, 25, 0, 0));
    add(0, 3'b010, 0, 0, 0, 0, o(0, 0, 0, 0, 35, 0, 0));
    add(0, 3'b000, 0, 1, 0, 0, o(0, 0, 0, 0, 35, 0, 1));
    add(1, 3'b100, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    idle(o(0, 0, 0, 0, 0, 0, 0));
    idle(o(0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 15; k++) begin
      add(0, 3'b010, 0, 0, 0, 0, o(0, 0, 0, 0, 10, 0, 0));
      add(0, 3'b000, 4'b0010, 0, 0, 0, o(4'b0010, 0, 0, 0, 0, k == 14 ? 4'b0010 : 4'b0000, 1));
      idle(o(0, 0, 0, 0, 0, k == 14 ? 4'b0010 : 4'b0000, 0));
    end
    add(0, 3'b010, 0, 0, 0, 0, o(0, 0, 0, 0, 10, 4'b0010, 0));
    add(0, 3'b000, 4'b0010, 0, 0, 0, o(0, 0, 0, 1, 10, 4'b0010, 0));
    add(0, 3'b000, 0, 0, 1, 2'd1, o(0, 0, 0, 0, 10, 0, 0));
    add(0, 3'b000, 4'b0110, 0, 0, 0, o(4'b0010, 0, 0, 0, 0, 0, 1));
    idle(o(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r;
      {bus.inQuarter, bus.inDime, bus.inNickel} = tbl[i].coins;
      bus.sel = tbl[i].sel;
      bus.cancel = tbl[i].cancel;
      bus.restock = tbl[i].rs;
      bus.restock_idx = tbl[i].ri;
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      act = {bus.outbev, bus.outquarter, bus.outdime, bus.outnickel, bus.coin_reject,
             bus.deny, bus.credit, bus.empty, bus.busy};
      want = sb.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL step %0d {bev,qdn,rej,deny,credit,empty,busy}: got %b credit=%0d, want %b credit=%0d",
                 i, act, act[14:5], want, want[14:5]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_core.md
VEND_CORE -- requirements
Module: vend_core

Interface
REQ-001 Parameter NUM_BEV, default 4: number of beverage channels (1..16).
REQ-002 Parameter CREDIT_W, default 10: credit/price width in cents.
REQ-003 Parameter MAX_CREDIT, default 500: highest credit accepted.
REQ-004 Parameter STOCK_W, default 4: per-channel stock counter width; full = all ones.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 inQuarter, inDime, inNickel  in  1 each  single-cycle coin-inserted pulses (25/10/5).
REQ-008 sel  in  NUM_BEV  beverage select; one bit per channel.
REQ-009 cancel  in  1  refund request pulse.
REQ-010 price  in  NUM_BEV*CREDIT_W  per-channel price, channel i at bits [i*CREDIT_W +: CREDIT_W].
REQ-011 restock, restock_idx  in  1, $clog2(NUM_BEV)  pulse sets stock[restock_idx] to full.
REQ-012 outbev  out  NUM_BEV  one-hot single-cycle dispense pulse.
REQ-013 outquarter, outdime, outnickel  out  1 each  change coin pulses, at most one high per cycle.
REQ-014 coin_reject  out  1  pulse: inserted coin returned unaccepted.
REQ-015 deny  out  1  pulse: selection refused (credit short or channel empty).
REQ-016 credit  out  CREDIT_W  current credit; empty  out  NUM_BEV  stock==0 per channel; busy  out  1  state != ACCEPT.

Function
REQ-017 FSM states ACCEPT, VEND, PAY_OUT; outputs registered, all responses appear the cycle after the causing input.
REQ-018 ACCEPT, coin only: credit += coin value if result <= MAX_CREDIT, else coin_reject pulse and credit unchanged.
REQ-019 More than one coin input high in a cycle: quarter accepted, the others each rejected (single coin_reject pulse).
REQ-020 ACCEPT, sel nonzero: lowest set index i chosen; if credit >= price[i] and stock[i] != 0 -> VEND, else deny pulse, stay ACCEPT.
REQ-021 VEND (one cycle): outbev[i] pulse, credit -= price[i], stock[i] decrements; next PAY_OUT if remainder > 0, else ACCEPT.
REQ-022 PAY_OUT: one coin per cycle, greedy: quarter if credit >= 25, else dime if >= 10, else nickel if >= 5; credit reduced by the coin paid.
REQ-023 PAY_OUT with 0 < credit < 5 (price not multiple of 5): remainder forfeited, credit <= 0, -> ACCEPT, no coin.
REQ-024 PAY_OUT -> ACCEPT the cycle after credit reaches 0.
REQ-025 cancel in ACCEPT with credit > 0 -> PAY_OUT; cancel with credit 0 is a no-op.
REQ-026 Priority within ACCEPT: cancel > sel > coin; a coin arriving with cancel or accepted sel is rejected.
REQ-027 Coins arriving in VEND or PAY_OUT rejected; sel and cancel ignored there.
REQ-028 restock honoured in every state; restock of the channel being decremented in the same cycle wins (stock = full).
REQ-029 restock_idx >= NUM_BEV ignored.

Reset
REQ-030 rst: state ACCEPT, credit 0, all stock = full, every pulse output 0, busy 0.
REQ-031 rst mid-VEND or mid-PAY_OUT aborts; outstanding change is not paid.
REQ-032 rst dominates all other inputs in the same cycle.

Structure
REQ-033 Package vend_pkg holds coin value constants (25/10/5) and the state enum.
REQ-034 Sub-module vend_change_unit: combinational greedy coin pick plus remainder, instantiated once.
REQ-035 Per-channel stock counters in a generate loop over NUM_BEV.

Verification
REQ-036 Quarter x4 then sel=0001, price0=75 -> outbev=0001, credit 25, outquarter one pulse, credit 0, busy deasserts.
REQ-037 Dime+nickel, sel channel 2 price 50 -> deny pulse, credit stays 15; then cancel -> outdime, outnickel on consecutive cycles.
REQ-038 Drain channel 1 to stock 0, select it with enough credit -> deny, empty[1]=1; restock idx 1 -> empty[1]=0, vend succeeds.
REQ-039 Credit 490, insert quarter -> coin_reject, credit 490; nickel -> credit 495; cancel -> 19 quarters, 2 dimes, 0 nickels.
REQ-040 Coin and sel same cycle -> coin_reject plus vend; coin during PAY_OUT -> coin_reject, change sequence unaffected.
REQ-041 rst during PAY_OUT at credit 35 -> next cycle credit 0, ACCEPT, no further coin pulses, stock full.
